// File: rtl/dino_jump_controller.sv
// dino_jump_controller: per-frame vertical position of the dinosaur.
// Ground/rising/falling FSM with integer velocity and constant gravity.
module dino_jump_controller #(
    parameter int GROUND_Y = 390,
    parameter int JUMP_VEL = 20,
    parameter int GRAVITY  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       jump_btn,
    input  logic       freeze,
    input  logic       restart,
    output logic [9:0] dino_y,
    output logic       airborne,
    output logic       jump_start
);

    typedef enum logic [1:0] {
        GROUND,
        RISING,
        FALLING
    } state_t;

    localparam logic        [9:0]  GY10 = 10'(GROUND_Y);
    localparam logic signed [10:0] GY11 = 11'(GROUND_Y);
    localparam logic        [9:0]  JV10 = 10'(JUMP_VEL);
    localparam logic signed [6:0]  JV7  = 7'(JUMP_VEL);
    localparam logic signed [6:0]  GR7  = 7'(GRAVITY);

    state_t             state;
    state_t             state_nx;
    logic [2:0]         sync;
    logic               btn_edge;
    logic               pending;
    logic               pending_nx;
    logic [9:0]         y;
    logic [9:0]         y_nx;
    logic signed [6:0]  v;
    logic signed [6:0]  v_nx;
    logic signed [6:0]  v_dec;
    logic signed [10:0] y_calc;
    logic               js_nx;

    // Two-flop synchroniser plus a third flop for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 3'b000;
        end else begin
            sync <= {sync[1:0], jump_btn};
        end
    end

    assign btn_edge = sync[1] & ~sync[2];

    // Motion state registers; all outputs come straight from these flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= GROUND;
            y          <= GY10;
            v          <= 7'sd0;
            pending    <= 1'b0;
            jump_start <= 1'b0;
        end else begin
            state      <= state_nx;
            y          <= y_nx;
            v          <= v_nx;
            pending    <= pending_nx;
            jump_start <= js_nx;
        end
    end

    assign y_calc = $signed({1'b0, y}) - $signed({{4{v[6]}}, v});
    assign v_dec  = v - GR7;

    // Next state: restart beats freeze, freeze beats the frame tick.
    always_comb begin
        state_nx   = state;
        y_nx       = y;
        v_nx       = v;
        pending_nx = pending;
        js_nx      = 1'b0;
        if (restart) begin
            state_nx   = GROUND;
            y_nx       = GY10;
            v_nx       = 7'sd0;
            pending_nx = 1'b0;
        end else if (!freeze) begin
            if (btn_edge) begin
                pending_nx = 1'b1;
            end
            if (frame_tick) begin
                pending_nx = 1'b0;
                unique case (state)
                    GROUND: begin
                        if (pending || btn_edge) begin
                            state_nx = RISING;
                            y_nx     = GY10 - JV10;
                            v_nx     = JV7 - GR7;
                            js_nx    = 1'b1;
                        end
                    end
                    RISING, FALLING: begin
                        if (y_calc >= GY11) begin
                            state_nx = GROUND;
                            y_nx     = GY10;
                            v_nx     = 7'sd0;
                        end else begin
                            y_nx     = y_calc[9:0];
                            v_nx     = v_dec;
                            state_nx = (v_dec > 7'sd0) ? RISING : FALLING;
                        end
                    end
                    default: begin
                        state_nx = GROUND;
                        y_nx     = GY10;
                        v_nx     = 7'sd0;
                    end
                endcase
            end
        end
    end

    assign dino_y   = y;
    assign airborne = (state != GROUND);

endmodule

// File: tb/tb_dino_jump_controller.sv
// Scoreboard bench for dino_jump_controller.
// Reference model integrates the jump physics per frame with plain integers.
module tb_dino_jump_controller;

    localparam int G  = 390;
    localparam int JV = 20;
    localparam int GR = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       jump_btn = 1'b0;
    logic       freeze = 1'b0;
    logic       restart = 1'b0;
    logic [9:0] y1;
    logic       air1;
    logic       js1;
    logic [9:0] y2;
    logic       air2;
    logic       js2;

    dino_jump_controller #(
        .GROUND_Y(G),
        .JUMP_VEL(JV),
        .GRAVITY (GR)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .frame_tick(frame_tick),
        .jump_btn  (jump_btn),
        .freeze    (freeze),
        .restart   (restart),
        .dino_y    (y1),
        .airborne  (air1),
        .jump_start(js1)
    );

    dino_jump_controller #(
        .GROUND_Y(390),
        .JUMP_VEL(7),
        .GRAVITY (2)
    ) dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .frame_tick(frame_tick),
        .jump_btn  (jump_btn),
        .freeze    (freeze),
        .restart   (restart),
        .dino_y    (y2),
        .airborne  (air2),
        .jump_start(js2)
    );

    always #5 clk = ~clk;

    typedef struct {
        int y;
        bit air;
        bit js;
    } exp_t;

    exp_t q[$];
    int   nvec = 0;
    int   nerr = 0;

    int my = G;
    int mv = 0;
    bit mair = 1'b0;
    bit mpend = 1'b0;

    task automatic chk(input string name, input int act, input int expv);
        nvec++;
        if (act != expv) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        my = G;
        mv = 0;
        mair = 1'b0;
        mpend = 1'b0;
    endtask

    // One frame of physics as the player sees it.
    task automatic model_tick(input bit rs, input bit fz, output bit js);
        int yn;
        js = 1'b0;
        if (rs) begin
            model_reset();
        end else if (!fz) begin
            if (!mair) begin
                if (mpend) begin
                    my = G - JV;
                    mv = JV - GR;
                    mair = 1'b1;
                    js = 1'b1;
                end
            end else begin
                yn = my - mv;
                if (yn >= G) begin
                    my = G;
                    mv = 0;
                    mair = 1'b0;
                end else begin
                    my = yn;
                    mv = mv - GR;
                end
            end
            mpend = 1'b0;
        end
    endtask

    // A frame: optional button press, then one tick cycle.
    task automatic frame(input bit press, input bit fz, input bit rs);
        exp_t e;
        bit js;
        freeze = fz;
        if (press) begin
            jump_btn = 1'b1;
            repeat (6) @(negedge clk);
            jump_btn = 1'b0;
            repeat (4) @(negedge clk);
            if (!fz) mpend = 1'b1;
        end else begin
            repeat (10) @(negedge clk);
        end
        frame_tick = 1'b1;
        restart = rs;
        model_tick(rs, fz, js);
        e.y = my;
        e.air = mair;
        e.js = js;
        q.push_back(e);
        @(negedge clk);
        frame_tick = 1'b0;
        restart = 1'b0;
    endtask

    bit upd = 1'b0;

    always @(posedge clk) begin
        upd <= rst_n && (frame_tick || restart);
    end

    // Monitor: every tick/restart cycle yields one registered update.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (upd) begin
                if (q.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("sb_y", int'(y1), e.y);
                    chk("sb_air", int'(air1), int'(e.air));
                    chk("sb_js", int'(js1), int'(e.js));
                end
            end else begin
                chk("js_idle", int'(js1), 0);
            end
        end
    end

    int exp2[8] = '{383, 378, 375, 374, 375, 378, 383, 390};

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_y", int'(y1), 390);
        chk("rst_air", int'(air1), 0);
        chk("rst_js", int'(js1), 0);
        chk("rst_y2", int'(y2), 390);

        for (int i = 0; i < 5; i++) begin
            frame(1'b0, 1'b0, 1'b0);
            chk("idle_y", int'(y1), 390);
            chk("idle_air", int'(air1), 0);
        end

        frame(1'b1, 1'b0, 1'b0);
        chk("takeoff_y", int'(y1), 370);
        chk("takeoff_js", int'(js1), 1);
        chk("takeoff_air", int'(air1), 1);
        for (int t = 2; t <= 41; t++) begin
            frame(t == 10, 1'b0, 1'b0);
            if (t == 20 || t == 21) chk("apex_y", int'(y1), 180);
            if (t == 41) begin
                chk("land_y", int'(y1), 390);
                chk("land_air", int'(air1), 0);
            end
        end

        frame(1'b1, 1'b0, 1'b0);
        chk("rejump_js", int'(js1), 1);
        chk("rejump_y", int'(y1), 370);
        for (int t = 2; t <= 15; t++) frame(1'b0, 1'b0, 1'b0);
        chk("t15_y", int'(y1), 195);
        for (int i = 0; i < 30; i++) frame(1'b0, 1'b1, 1'b0);
        chk("frozen_y", int'(y1), 195);
        chk("frozen_air", int'(air1), 1);
        frame(1'b0, 1'b0, 1'b0);
        chk("resume_y", int'(y1), 190);
        for (int t = 17; t <= 24; t++) frame(1'b0, 1'b0, 1'b0);
        frame(1'b0, 1'b1, 1'b1);
        chk("restart_y", int'(y1), 390);
        chk("restart_air", int'(air1), 0);

        frame(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) frame(1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_y", int'(y1), 390);
        chk("async_air", int'(air1), 0);
        chk("async_js", int'(js1), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        frame(1'b1, 1'b0, 1'b0);
        chk("d2_js", int'(js2), 1);
        chk("d2_y", int'(y2), exp2[0]);
        for (int i = 1; i < 8; i++) begin
            frame(1'b0, 1'b0, 1'b0);
            chk("d2_y", int'(y2), exp2[i]);
        end
        chk("d2_air", int'(air2), 0);

        for (int i = 0; i < 300; i++) begin
            frame(($urandom % 4) == 0, ($urandom % 8) == 0, ($urandom % 32) == 0);
        end
        freeze = 1'b0;

        repeat (3) @(negedge clk);
        if (q.size() != 0) chk("sb_drain", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
